bus_arbiter: RTL and testbench

- Central controller at the shared-bus end of the PE interconnect.
- Consumes the pipelined PE-side request signals (address, data, valid, read-buffer-full) and grants the single shared data/address bus to one PE per cycle using round-robin.
- Drives the bus word plus one-hot write-acknowledge and read-strobe vectors back toward the PEs through the bus pipeline.
- Compensates for the pipeline round-trip delay so stale requests and stale full flags never cause duplicate or overflowing transfers.

---
 rtl/bus_arbiter.sv | 109 ++++++++++
 tb/tb_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared PE bus. It masks each granted source for the pipeline round trip.
// Optional statistics counters are enabled by defining BUS_ARB_STATS_EN.
module bus_arbiter #(
   parameter int NUM_PE       = 8,
   parameter int DATA_LEN     = 16,
   parameter int BUS_ADDR_LEN = 3,
   parameter int NUM_STAGES   = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [BUS_ADDR_LEN*NUM_PE-1:0] i_addr_to_bus_p,
   input  logic [DATA_LEN*NUM_PE-1:0]     i_data_to_bus_p,
   input  logic [NUM_PE-1:0]              i_valid_to_bus_p,
   input  logic [NUM_PE*NUM_PE-1:0]       i_rd_buffer_full_p,
   output logic [DATA_LEN-1:0]            o_data_bus,
   output logic [BUS_ADDR_LEN-1:0]        o_addr_bus,
   output logic [NUM_PE-1:0]              o_wr_to_bus,
   output logic [NUM_PE-1:0]              o_rd_from_bus
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [31:0]                    o_grant_count,
   output logic [31:0]                    o_stall_count
`endif
);

   // Ack out, valid drop back, plus PE register and full-flag update.
   localparam int MASK   = 2*NUM_STAGES + 2;
   localparam int MASK_W = $clog2(MASK + 1);

   logic [MASK_W-1:0]       mask_cnt [NUM_PE];
   logic [BUS_ADDR_LEN-1:0] last_grant;

   logic [BUS_ADDR_LEN-1:0] dst_p0   [NUM_PE];
   logic [DATA_LEN-1:0]     src_data [NUM_PE];
   logic [NUM_PE-1:0]       unmasked_p0;
   logic [NUM_PE-1:0]       elig_p0;
   logic                    gnt_vld_p0;
   logic [BUS_ADDR_LEN-1:0] gnt_idx_p0;
   logic [BUS_ADDR_LEN-1:0] cand_p0;

   // Stage p0: per-source eligibility from the sampled request signals
   for (genvar s = 0; s < NUM_PE; s++) begin : g_src
      localparam logic [BUS_ADDR_LEN-1:0] SIDX = BUS_ADDR_LEN'(s);
      assign dst_p0[s]      = i_addr_to_bus_p[s*BUS_ADDR_LEN +: BUS_ADDR_LEN];
      assign src_data[s]    = i_data_to_bus_p[s*DATA_LEN +: DATA_LEN];
      assign unmasked_p0[s] = (mask_cnt[s] == '0);
      // Full flag for source s lives in destination d's slice: flat index d*NUM_PE + s.
      assign elig_p0[s]     = i_valid_to_bus_p[s] & unmasked_p0[s]
                              & ~i_rd_buffer_full_p[{dst_p0[s], SIDX}];
   end

   always_comb begin
      gnt_vld_p0 = 1'b0;
      gnt_idx_p0 = last_grant;
      cand_p0    = '0;
      for (int i = 1; i <= NUM_PE; i++) begin
         cand_p0 = last_grant + BUS_ADDR_LEN'(i);
         if (!gnt_vld_p0 && elig_p0[cand_p0]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = cand_p0;
         end
      end
   end

   // Stage p1: registered bus outputs, pointer and mask counters
   always_ff @(posedge clk) begin
      if (rst) begin
         o_data_bus    <= '0;
         o_addr_bus    <= '0;
         o_wr_to_bus   <= '0;
         o_rd_from_bus <= '0;
         last_grant    <= '1;
         for (int s = 0; s < NUM_PE; s++) mask_cnt[s] <= '0;
      end else begin
         for (int s = 0; s < NUM_PE; s++) begin
            if (gnt_vld_p0 && gnt_idx_p0 == BUS_ADDR_LEN'(s))
               mask_cnt[s] <= MASK_W'(MASK);
            else if (mask_cnt[s] != '0)
               mask_cnt[s] <= mask_cnt[s] - 1'b1;
         end
         o_wr_to_bus   <= '0;
         o_rd_from_bus <= '0;
         if (gnt_vld_p0) begin
            o_wr_to_bus   <= NUM_PE'(1) << gnt_idx_p0;
            o_rd_from_bus <= NUM_PE'(1) << dst_p0[gnt_idx_p0];
            o_data_bus    <= src_data[gnt_idx_p0];
            o_addr_bus    <= gnt_idx_p0;
            last_grant    <= gnt_idx_p0;
         end
      end
   end

`ifdef BUS_ARB_STATS_EN
   logic stall_p0;
   // A stall is an unmasked request that still lost the cycle, i.e. full-blocked.
   assign stall_p0 = !gnt_vld_p0 && |(i_valid_to_bus_p & unmasked_p0);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_grant_count <= '0;
         o_stall_count <= '0;
      end else begin
         if (gnt_vld_p0) o_grant_count <= o_grant_count + 32'd1;
         if (stall_p0)   o_stall_count <= o_stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (NUM_PE=8, NUM_STAGES=3) plus a NUM_STAGES=0 instance.
// Statistics outputs are checked when BUS_ARB_STATS_EN is defined.
module tb_bus_arbiter;

   logic          clk;
   logic          rst;
   logic [23:0]   addr_in;
   logic [127:0]  data_in;
   logic [7:0]    valid_in;
   logic [63:0]   full_in;
   logic [15:0]   data_bus, data_bus0;
   logic [2:0]    addr_bus, addr_bus0;
   logic [7:0]    wr_bus, wr_bus0;
   logic [7:0]    rd_bus, rd_bus0;
`ifdef BUS_ARB_STATS_EN
   logic [31:0]   grant_cnt, stall_cnt, grant_cnt0, stall_cnt0;
`endif

   bus_arbiter #(.NUM_PE(8), .DATA_LEN(16), .BUS_ADDR_LEN(3), .NUM_STAGES(3)) u_dut (
      .clk(clk), .rst(rst),
      .i_addr_to_bus_p(addr_in), .i_data_to_bus_p(data_in),
      .i_valid_to_bus_p(valid_in), .i_rd_buffer_full_p(full_in),
      .o_data_bus(data_bus), .o_addr_bus(addr_bus),
      .o_wr_to_bus(wr_bus), .o_rd_from_bus(rd_bus)
`ifdef BUS_ARB_STATS_EN
      , .o_grant_count(grant_cnt), .o_stall_count(stall_cnt)
`endif
   );

   bus_arbiter #(.NUM_PE(8), .DATA_LEN(16), .BUS_ADDR_LEN(3), .NUM_STAGES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .i_addr_to_bus_p(addr_in), .i_data_to_bus_p(data_in),
      .i_valid_to_bus_p(valid_in), .i_rd_buffer_full_p(full_in),
      .o_data_bus(data_bus0), .o_addr_bus(addr_bus0),
      .o_wr_to_bus(wr_bus0), .o_rd_from_bus(rd_bus0)
`ifdef BUS_ARB_STATS_EN
      , .o_grant_count(grant_cnt0), .o_stall_count(stall_cnt0)
`endif
   );

   typedef struct {
      int          cyc;
      logic [7:0]  wr;
      logic [7:0]  rd;
      logic [15:0] data;
      logic [2:0]  addr;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   bit          rst_smp  = 1'b0;
   logic [15:0] hold_data = '0;
   logic [2:0]  hold_addr = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= rst;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Outputs are sampled mid-cycle; each cycle either matches a queued grant or must be idle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_smp) begin
         hold_data = '0;
         hold_addr = '0;
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         chk_eq("wr", 32'(wr_bus), 32'(e.wr));
         chk_eq("rd", 32'(rd_bus), 32'(e.rd));
         chk_eq("data", 32'(data_bus), 32'(e.data));
         chk_eq("addr", 32'(addr_bus), 32'(e.addr));
         hold_data = e.data;
         hold_addr = e.addr;
      end else begin
         chk_eq("idle_wr", 32'(wr_bus), 32'd0);
         chk_eq("idle_rd", 32'(rd_bus), 32'd0);
         chk_eq("hold_data", 32'(data_bus), 32'(hold_data));
         chk_eq("hold_addr", 32'(addr_bus), 32'(hold_addr));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int at, input int g, input int d, input logic [15:0] w);
      exp_t e;
      e.cyc  = at;
      e.wr   = 8'd1 << g;
      e.rd   = 8'd1 << d;
      e.data = w;
      e.addr = 3'(g);
      sb.push_back(e);
   endtask

   task automatic set_src(input int s, input bit v, input int d, input logic [15:0] w);
      valid_in[s]          = v;
      addr_in[s*3 +: 3]    = 3'(d);
      data_in[s*16 +: 16]  = w;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      valid_in = '0;
      addr_in  = '0;
      data_in  = '0;
      full_in  = '0;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      int c;
      rst      = 1'b1;
      valid_in = '0;
      addr_in  = '0;
      data_in  = '0;
      full_in  = '0;

      do_reset();
      chk_eq("rst_wr", 32'(wr_bus), 32'd0);
      chk_eq("rst_rd", 32'(rd_bus), 32'd0);
      chk_eq("rst_data", 32'(data_bus), 32'd0);
      chk_eq("rst_addr", 32'(addr_bus), 32'd0);

      // Single request held: regranted 9 cycles later; the NUM_STAGES=0 instance every 3rd cycle.
      c = cyc;
      set_src(2, 1'b1, 5, 16'hBEEF);
      push_exp(c + 1, 2, 5, 16'hBEEF);
      push_exp(c + 10, 2, 5, 16'hBEEF);
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         chk_eq("s0_wr", 32'(wr_bus0), (k % 3 == 1) ? 32'h04 : 32'h00);
      end
      valid_in = '0;
      tick(3);

      // Round-robin across PEs 0, 3, 7
      do_reset();
      c = cyc;
      set_src(0, 1'b1, 1, 16'h1000);
      set_src(3, 1'b1, 1, 16'h1003);
      set_src(7, 1'b1, 1, 16'h1007);
      push_exp(c + 1, 0, 1, 16'h1000);
      push_exp(c + 2, 3, 1, 16'h1003);
      push_exp(c + 3, 7, 1, 16'h1007);
      push_exp(c + 10, 0, 1, 16'h1000);
      push_exp(c + 11, 3, 1, 16'h1003);
      push_exp(c + 12, 7, 1, 16'h1007);
      tick(12);
      valid_in = '0;
      tick(2);
`ifdef BUS_ARB_STATS_EN
      chk_eq("rr_grants", grant_cnt, 32'd6);
      chk_eq("rr_stalls", stall_cnt, 32'd0);
`endif

      // Full blocking: destination 6's buffer for source 4 full for 10 cycles
      do_reset();
      c = cyc;
      set_src(4, 1'b1, 6, 16'h4444);
      full_in[6*8 + 4] = 1'b1;
      tick(10);
      full_in[6*8 + 4] = 1'b0;
      push_exp(c + 11, 4, 6, 16'h4444);
      tick(1);
      valid_in = '0;
      tick(2);
`ifdef BUS_ARB_STATS_EN
      chk_eq("full_stalls", stall_cnt, 32'd10);
      chk_eq("full_grants", grant_cnt, 32'd1);
`endif

      // Wrap-around after last grant to PE7
      do_reset();
      c = cyc;
      set_src(7, 1'b1, 2, 16'h7777);
      push_exp(c + 1, 7, 2, 16'h7777);
      tick(1);
      valid_in[7] = 1'b0;
      set_src(6, 1'b1, 3, 16'h6666);
      set_src(1, 1'b1, 4, 16'h1111);
      push_exp(c + 2, 1, 4, 16'h1111);
      push_exp(c + 3, 6, 3, 16'h6666);
      tick(2);
      valid_in = '0;
      tick(2);

      // Reset mid-operation clears outputs and the mask
      do_reset();
      c = cyc;
      set_src(3, 1'b1, 0, 16'h3333);
      push_exp(c + 1, 3, 0, 16'h3333);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      push_exp(c + 3, 3, 0, 16'h3333);
      tick(1);
      valid_in = '0;
      tick(2);

      // Self-addressed word, and a transposed full bit that must not block
      do_reset();
      c = cyc;
      set_src(0, 1'b1, 0, 16'hA0A0);
      set_src(5, 1'b1, 2, 16'hA5A5);
      full_in[5*8 + 2] = 1'b1;
      push_exp(c + 1, 0, 0, 16'hA0A0);
      push_exp(c + 2, 5, 2, 16'hA5A5);
      tick(2);
      valid_in = '0;
      full_in  = '0;
      tick(3);

      chk_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
